sha256_hdr_sequencer: RTL and testbench

//  Sequences the shared sha256 compression core to hash one 80-byte block header.

---
 rtl/sha256_hdr_sequencer.sv | 174 +++++++++++++++++
 tb/tb_sha256_hdr_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_hdr_sequencer.sv
// Sequences one shared SHA-256 compression core over an 80-byte header (two passes).
// Define SHA256D_EN to append a third pass over the first digest (double SHA-256).
module sha256_hdr_sequencer #(
    parameter int unsigned WDOG_CYCLES = 255
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [639:0] header,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [255:0] digest,
    output logic         core_enable,
    output logic [511:0] core_data,
    output logic [255:0] core_current_hash,
    input  logic [255:0] core_hash,
    input  logic         core_hash_done
);
    localparam int unsigned WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P1_REQ  = 3'd1,
        P1_WAIT = 3'd2,
        P2_REQ  = 3'd3,
        P2_WAIT = 3'd4,
`ifdef SHA256D_EN
        P3_REQ  = 3'd5,
        P3_WAIT = 3'd6,
`endif
        FIN     = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [639:0]    hdr_q, hdr_d;
    logic [255:0]    mid_q, mid_d;
    logic [255:0]    res_q, res_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            busy_d, done_d, error_d, core_enable_d;
    logic [255:0]    digest_d, core_current_hash_d;
    logic [511:0]    core_data_d;
    logic            wd_run;

    // State and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q           <= IDLE;
            hdr_q             <= '0;
            mid_q             <= '0;
            res_q             <= '0;
            wd_q              <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
            digest            <= '0;
            core_enable       <= 1'b0;
            core_data         <= '0;
            core_current_hash <= '0;
        end else begin
            state_q           <= state_d;
            hdr_q             <= hdr_d;
            mid_q             <= mid_d;
            res_q             <= res_d;
            wd_q              <= wd_d;
            busy              <= busy_d;
            done              <= done_d;
            error             <= error_d;
            digest            <= digest_d;
            core_enable       <= core_enable_d;
            core_data         <= core_data_d;
            core_current_hash <= core_current_hash_d;
        end
    end

    // Next-state and next-output logic; enable and block launch together from each REQ state
    always_comb begin
        state_d             = state_q;
        hdr_d               = hdr_q;
        mid_d               = mid_q;
        res_d               = res_q;
        wd_d                = wd_q;
        busy_d              = busy;
        done_d              = 1'b0;
        error_d             = 1'b0;
        digest_d            = digest;
        core_enable_d       = 1'b0;
        core_data_d         = core_data;
        core_current_hash_d = core_current_hash;
        wd_run              = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    hdr_d   = header;
                    busy_d  = 1'b1;
                    state_d = P1_REQ;
                end
            end
            P1_REQ: begin
                core_enable_d       = 1'b1;
                core_data_d         = hdr_q[639:128];
                core_current_hash_d = IV;
                wd_d                = '0;
                state_d             = P1_WAIT;
            end
            P1_WAIT: begin
                if (core_hash_done) begin
                    mid_d   = core_hash;
                    state_d = P2_REQ;
                end else begin
                    wd_run = 1'b1;
                end
            end
            P2_REQ: begin
                core_enable_d       = 1'b1;
                core_data_d         = {hdr_q[127:0], 32'h80000000, 288'b0, 64'd640};
                core_current_hash_d = mid_q;
                wd_d                = '0;
                state_d             = P2_WAIT;
            end
            P2_WAIT: begin
                if (core_hash_done) begin
                    res_d = core_hash;
`ifdef SHA256D_EN
                    state_d = P3_REQ;
`else
                    state_d = FIN;
`endif
                end else begin
                    wd_run = 1'b1;
                end
            end
`ifdef SHA256D_EN
            P3_REQ: begin
                core_enable_d       = 1'b1;
                core_data_d         = {res_q, 32'h80000000, 160'b0, 64'd256};
                core_current_hash_d = IV;
                wd_d                = '0;
                state_d             = P3_WAIT;
            end
            P3_WAIT: begin
                if (core_hash_done) begin
                    res_d   = core_hash;
                    state_d = FIN;
                end else begin
                    wd_run = 1'b1;
                end
            end
`endif
            FIN: begin
                digest_d = res_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Watchdog only advances when the core has not answered this cycle
        if (wd_run) begin
            if (wd_q == WD_LAST) begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sha256_hdr_sequencer.sv
// Bench for sha256_hdr_sequencer: behavioural SHA-256 core stub plus a byte-level reference hash.
// Build with SHA256D_EN defined to check the double-hash configuration.
module tb_sha256_hdr_sequencer;
    localparam int unsigned WDOG = 100;
`ifdef SHA256D_EN
    localparam int unsigned NPASS = 3;
`else
    localparam int unsigned NPASS = 2;
`endif
    localparam int NV = 6;
    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [639:0] GENESIS = {32'h01000000, 256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};

    logic         clk = 1'b0;
    logic         n_rst, start, busy, done, error, core_enable, core_hash_done;
    logic [639:0] header;
    logic [255:0] digest, core_current_hash, core_hash;
    logic [511:0] core_data;

    sha256_hdr_sequencer #(.WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .header(header),
        .busy(busy), .done(done), .error(error), .digest(digest),
        .core_enable(core_enable), .core_data(core_data), .core_current_hash(core_current_hash),
        .core_hash(core_hash), .core_hash_done(core_hash_done));

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7]
                 + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Full SHA-256 of the first nbytes of v (left-aligned, big-endian), padded in software
    function automatic logic [255:0] sha256_vec(input logic [639:0] v, input int nbytes);
        logic [7:0]      p[$];
        logic [511:0]    blk;
        logic [255:0]    hv;
        longint unsigned nbits;
        nbits = 64'(nbytes) * 64'd8;
        for (int i = 0; i < nbytes; i++) p.push_back(v[639-8*i -: 8]);
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(nbits >> (8*i)));
        hv = IV;
        for (int b = 0; b < p.size() / 64; b++) begin
            for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = p[64*b+i];
            hv = compress(hv, blk);
        end
        return hv;
    endfunction

    function automatic logic [255:0] ref_hash(input logic [639:0] h);
        logic [255:0] d;
        d = sha256_vec(h, 80);
`ifdef SHA256D_EN
        d = sha256_vec({d, 384'b0}, 32);
`endif
        return d;
    endfunction

    function automatic logic [639:0] rand_hdr();
        logic [639:0] h;
        for (int w = 0; w < 20; w++) h[32*w +: 32] = $urandom();
        return h;
    endfunction

    // Core stub: samples data one cycle after enable, answers lat_cfg cycles later unless hung
    int unsigned  lat_cfg = 3;
    logic         hang_cfg = 1'b0;
    logic         inj_done = 1'b0;
    logic         pend, smp;
    int unsigned  cnt;
    logic [511:0] s_data;
    logic [255:0] s_ch;
    int unsigned  en_cnt = 0, overlap = 0;
    logic [255:0] ch_log[$];

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pend <= 1'b0; smp <= 1'b0; cnt <= 0;
            core_hash_done <= 1'b0; core_hash <= '0;
        end else begin
            core_hash_done <= inj_done;
            if (core_enable) begin
                if (pend) overlap <= overlap + 1;
                pend   <= !hang_cfg;
                smp    <= 1'b1;
                cnt    <= lat_cfg;
                en_cnt <= en_cnt + 1;
            end else if (smp) begin
                smp    <= 1'b0;
                s_data <= core_data;
                s_ch   <= core_current_hash;
                ch_log.push_back(core_current_hash);
            end else if (pend) begin
                if (cnt == 0) begin
                    pend           <= 1'b0;
                    core_hash_done <= 1'b1;
                    core_hash      <= compress(s_ch, s_data);
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    int unsigned done_cnt = 0, err_cnt = 0, en_bad = 0;
    logic        en_prev = 1'b0;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (core_enable && en_prev) en_bad++;
        en_prev = core_enable;
    end

    int unsigned n_chk = 0, n_pass = 0;
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at a negedge; holds start for one cycle then scrambles header
    task automatic start_txn(input logic [639:0] hdr);
        start = 1'b1; header = hdr;
        @(negedge clk);
        start = 1'b0; header = ~hdr;
    endtask

    task automatic wait_end(output logic got_done, output logic got_err);
        got_done = 1'b0; got_err = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done || error) begin
                got_done = done; got_err = error;
                break;
            end
        end
    endtask

    typedef struct {
        logic [639:0] hdr;
        int unsigned  lat;
        logic [255:0] exp;
    } vec_t;
    vec_t vec [NV];

    logic [639:0] ha, hb;
    logic [255:0] ra, rb, dig0, mid_act;
    logic         gd, ge, got, held;
    int unsigned  e0, d0, r0, b0;
    int           k_en, k_err;

    initial begin
        n_rst = 1'b0; start = 1'b0; header = '0;
        vec[0].hdr = '0;        vec[0].lat = 2;
        vec[1].hdr = GENESIS;   vec[1].lat = 0;
        vec[2].hdr = '1;        vec[2].lat = 7;
        for (int i = 3; i < NV; i++) begin
            vec[i].hdr = rand_hdr(); vec[i].lat = $urandom_range(0, 30);
        end
        for (int i = 0; i < NV; i++) vec[i].exp = ref_hash(vec[i].hdr);

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done_error", {done, error}, 0);
        chk("rst_digest", digest, 0);
        chk("rst_core_enable", core_enable, 0);
        chk("rst_core_data", |core_data, 0);
        chk("rst_core_hash", core_current_hash, 0);
        n_rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            lat_cfg = vec[i].lat;
            e0 = en_cnt; d0 = done_cnt; r0 = err_cnt; b0 = ch_log.size();
            start_txn(vec[i].hdr);
            wait_end(gd, ge);
            chk($sformatf("v%0d_done", i), gd, 1);
            chk($sformatf("v%0d_digest", i), digest, vec[i].exp);
            chk($sformatf("v%0d_busy_low", i), busy, 0);
            mid_act = (ch_log.size() > b0 + 1) ? ch_log[b0+1] : '0;
            chk($sformatf("v%0d_midstate", i), mid_act, compress(IV, vec[i].hdr[639:128]));
`ifdef SHA256D_EN
            mid_act = (ch_log.size() > b0 + 2) ? ch_log[b0+2] : '0;
            chk($sformatf("v%0d_pass3_iv", i), mid_act, IV);
`endif
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), done, 0);
            chk($sformatf("v%0d_enables", i), en_cnt - e0, NPASS);
            chk($sformatf("v%0d_done_count", i), done_cnt - d0, 1);
            chk($sformatf("v%0d_no_error", i), err_cnt - r0, 0);
        end
`ifdef SHA256D_EN
        chk("genesis_const", vec[1].exp, 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000);
`endif

        // start held high while busy: one transaction only, on the first header
        lat_cfg = 5; e0 = en_cnt; d0 = done_cnt;
        ha = rand_hdr(); ra = ref_hash(ha);
        start = 1'b1; header = ha; got = 1'b0;
        for (int k = 0; k < 500 && !got; k++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; start = 1'b0; end
            else begin header = rand_hdr(); start = 1'b1; end
        end
        start = 1'b0;
        chk("busy_start_done", got, 1);
        chk("busy_start_digest", digest, ra);
        repeat (5) @(negedge clk);
        chk("busy_start_idle", busy, 0);
        chk("busy_start_enables", en_cnt - e0, NPASS);
        chk("busy_start_done_count", done_cnt - d0, 1);

        // stray core_hash_done while idle
        e0 = en_cnt; d0 = done_cnt; dig0 = digest;
        inj_done = 1'b1; @(negedge clk); inj_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_done_busy", busy, 0);
        chk("stray_done_digest", digest, dig0);
        chk("stray_done_count", {done_cnt - d0, en_cnt - e0}, 0);

        // hung core: watchdog fires WDOG cycles after entering P1_WAIT
        hang_cfg = 1'b1; dig0 = digest; d0 = done_cnt;
        start = 1'b1; header = rand_hdr(); k_en = -1; k_err = -1;
        for (int k = 1; k <= 400 && k_err < 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (core_enable && k_en < 0) k_en = k;
            if (error) k_err = k;
        end
        chk("wdog_fired", k_err > 0, 1);
        chk("wdog_delay", 32'(k_err - k_en), WDOG);
        chk("wdog_busy", busy, 0);
        chk("wdog_digest", digest, dig0);
        @(negedge clk);
        chk("wdog_pulse", error, 0);
        chk("wdog_no_done", done_cnt - d0, 0);
        hang_cfg = 1'b0; lat_cfg = 9;
        ha = rand_hdr();
        start_txn(ha); wait_end(gd, ge);
        chk("wdog_recover_done", gd, 1);
        chk("wdog_recover_digest", digest, ref_hash(ha));
        @(negedge clk);

        // reset while waiting on pass 2
        lat_cfg = 40; e0 = en_cnt;
        start_txn(rand_hdr());
        for (int k = 0; k < 1000 && en_cnt < e0 + 2; k++) @(negedge clk);
        chk("rst_mid_reached_p2", en_cnt - e0, 2);
        repeat (5) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done_error", {done, error}, 0);
        chk("rst_mid_digest", digest, 0);
        chk("rst_mid_enable", core_enable, 0);
        @(negedge clk); n_rst = 1'b1; @(negedge clk);
        lat_cfg = 1; ha = rand_hdr();
        start_txn(ha); wait_end(gd, ge);
        chk("rst_mid_fresh_done", gd, 1);
        chk("rst_mid_fresh_digest", digest, ref_hash(ha));
        @(negedge clk);

        // back-to-back: second start in the cycle done is visible
        lat_cfg = 4; ha = rand_hdr(); hb = rand_hdr();
        ra = ref_hash(ha); rb = ref_hash(hb);
        start_txn(ha); wait_end(gd, ge);
        chk("b2b_first_digest", digest, ra);
        d0 = done_cnt; start = 1'b1; header = hb; held = 1'b1; got = 1'b0;
        for (int k = 0; k < 2000 && !got; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) got = 1'b1;
            else if (digest !== ra) held = 1'b0;
        end
        chk("b2b_second_done", got, 1);
        chk("b2b_digest_held", held, 1);
        chk("b2b_second_digest", digest, rb);

        repeat (3) @(negedge clk);
        chk("enable_single_cycle", en_bad, 0);
        chk("one_pass_outstanding", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
